// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB3 completer that fronts a word-addressed register memory.
// A fixed number of wait states can be inserted before each transfer completes.
//
// Optional feature macro: APB_SLAVE_PSLVERR_EN
//   defined   -> misaligned or out-of-range addresses are flagged. Errored writes
//                are dropped, errored reads return 0, and PSLVERR=1 on completion.
//   undefined -> PSLVERR is tied 0. Addresses alias modulo MEM_DEPTH words.
//
// Ports:
//   PCLK     in   bus clock, all logic on rising edge
//   PRESETn  in   synchronous active-low reset (also clears the memory)
//   PSEL     in   completer select
//   PENABLE  in   access phase
//   PADDR    in   byte address
//   PWRITE   in   1 = write, 0 = read
//   PWDATA   in   write data
//   PRDATA   out  read data, loaded at the setup edge
//   PREADY   out  transfer completes this cycle
//   PSLVERR  out  error on completing transfer (only with PREADY=1)
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int         IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                r_state, w_next;
  logic [3:0]            r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_setup;
  logic                  w_ready;
  logic                  w_done;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_addr_err;

  // A setup cycle is only accepted from IDLE; PSEL+PENABLE without a
  // preceding setup leaves the FSM idle.
  assign w_setup = (r_state == S_IDLE) && PSEL && !PENABLE;
  // Ready is decoded from registered state only, never from PADDR.
  assign w_ready = (r_state == S_ACCESS) && (r_cnt == WS);
  assign w_done  = w_ready && PSEL && PENABLE;
  assign w_idx   = PADDR[IDX_W+1:2];

`ifdef APB_SLAVE_PSLVERR_EN
  // Upper bits nonzero <=> PADDR >= MEM_DEPTH*4.
  assign w_addr_err = (PADDR[1:0] != 2'b00) || (|PADDR[ADDR_WIDTH-1:IDX_W+2]);
  assign PSLVERR    = w_ready && r_err;
`else
  logic w_unused;
  assign w_unused   = ^{PADDR[ADDR_WIDTH-1:IDX_W+2], PADDR[1:0]};
  assign w_addr_err = 1'b0;
  assign PSLVERR    = 1'b0;
`endif

  assign PREADY = w_ready;
  assign PRDATA = r_rdata;

  // FSM state register
  always_ff @(posedge PCLK) begin
    if (!PRESETn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_setup) w_next = S_ACCESS;
      S_ACCESS: begin
        if (!PSEL)                   w_next = S_IDLE;  // abort, nothing committed
        else if (PENABLE && w_ready) w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: transfer latch, wait counter, read data, memory
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_setup) begin
        r_idx   <= w_idx;
        r_write <= PWRITE;
        r_wdata <= PWDATA;
        r_err   <= w_addr_err;
        r_cnt   <= '0;
        // Read data is captured at setup so it is stable through the wait states.
        r_rdata <= w_addr_err ? '0 : r_mem[w_idx];
      end else if ((r_state == S_ACCESS) && !w_ready) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_done && r_write && !r_err) r_mem[r_idx] <= r_wdata;
    end
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB3 completer (slave) holding a word-addressed register memory with a programmable number of wait states. It sits on the APB side of the AHB-to-APB bridge as the bus target, answering the bridge's PSEL/PENABLE transfers with PREADY, PRDATA and PSLVERR. It also serves as the reference target for bridge-level simulation and assertion runs.

## Interface
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width; word = DATA_WIDTH/8 bytes, must be 32
- MEM_DEPTH, 16, number of words; power of two, ≥ 2
- WAIT_STATES, 0, ACCESS cycles with PREADY low before completion; 0..15

Ports:
- PCLK  in  1  bus clock; all logic on rising edge
- PRESETn  in  1  reset, synchronous and active-low
- PSEL  in  1  completer select
- PENABLE  in  1  access phase
- PADDR  in  ADDR_WIDTH  byte address
- PWRITE  in  1  1 = write, 0 = read
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data, valid when PREADY=1 on a read
- PREADY  out  1  transfer completes this cycle
- PSLVERR  out  1  error on completing transfer, valid only with PREADY=1

## Operation
- FSM states: IDLE, ACCESS.
- IDLE:
  - PSEL=1 with PENABLE=0 is a setup cycle. At the edge: latch PADDR, PWRITE and PWDATA; clear wait counter; go to ACCESS.
  - PSEL=1 with PENABLE=1 (no setup) is ignored. PREADY stays 0 and the state stays IDLE.
- ACCESS:
  - PREADY = (wait counter == WAIT_STATES); the counter increments each cycle while PREADY=0.
  - When PSEL=1, PENABLE=1 and PREADY=1: the transfer completes at that edge. A write commits to the latched index; the state returns to IDLE.
  - PSEL=0 in ACCESS aborts the transfer: no write, return to IDLE, PREADY=0.
- Index = latched PADDR[log2(MEM_DEPTH)+1:2].
- Address error: latched PADDR ≥ MEM_DEPTH*4, or PADDR[1:0] ≠ 0.
- Read data: PRDATA is loaded from the memory at the setup edge and held until the next setup. On an address error PRDATA = 0.
- Back-to-back transfers: the cycle after completion is a setup cycle (PSEL=1, PENABLE=0), which IDLE accepts immediately.

## Timing
- Reset (PRESETn=0 at an edge):
  - PRDATA = 0, PREADY = 0, PSLVERR = 0, state = IDLE, counter = 0.
  - All MEM_DEPTH words are cleared to 0.
  - Reset asserted mid-transfer discards the transfer; no write.
- PREADY and PSLVERR are decoded from registered state (state, counter, latched error flag). They do not depend combinationally on PADDR.
- Latency:
  - Minimum transfer: 2 cycles (setup + 1 access) with WAIT_STATES=0.
  - General case: 2 + WAIT_STATES cycles.
- Write visibility: a read set up in the cycle immediately after a write's completion returns the new data.
- PSLVERR is asserted only in the completing cycle (PREADY=1) and is 0 otherwise.

## Configuration
- APB_SLAVE_PSLVERR_EN defined:
  - The address error check is active.
  - Errored writes are dropped; errored reads return 0.
  - PSLVERR=1 on completion of an errored transfer.
- APB_SLAVE_PSLVERR_EN undefined:
  - PSLVERR is tied 0; no error decode logic.
  - Index uses the PADDR bits above only, so out-of-range addresses alias modulo MEM_DEPTH and PADDR[1:0] is ignored.

## Test plan
- Reset, then read all 16 words with WAIT_STATES=0 → each read: PRDATA=0, PREADY=1 in the 2nd cycle, PSLVERR=0.
- Write 0xDEADBEEF to 0x08, then a back-to-back read of 0x08 → PRDATA=0xDEADBEEF, each transfer takes 2 cycles.
- WAIT_STATES=3, write 0x12345678 to 0x3C → PREADY low for 3 ACCESS cycles, high on the 4th; readback returns 0x12345678.
- With APB_SLAVE_PSLVERR_EN:
  - Write 0xA5A5A5A5 to 0x40 → PSLVERR=1 with PREADY, and word 0 is unchanged.
  - Read 0x06 → PRDATA=0, PSLVERR=1.
- Without APB_SLAVE_PSLVERR_EN: write 0xA5A5A5A5 to 0x40 → PSLVERR=0; a read of 0x00 returns 0xA5A5A5A5.
- Abort and reset cases (WAIT_STATES=2):
  - Write to 0x04 with PSEL dropped after the 1st ACCESS cycle → word 1 unchanged, FSM in IDLE, and the next transfer completes normally.
  - PRESETn pulsed low mid-ACCESS → all outputs 0 next cycle and memory cleared.
